code_run_encoder: RTL and testbench

// - Downstream consumer of the 2-bit control code produced by the nested
//   if/else decode stage (output b, values 0..3).
// - Run-length encodes the code stream: each maximal run of identical valid

---
 rtl/code_run_encoder.sv | 124 ++++++++++++
 tb/tb_code_run_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/code_run_encoder.sv
// rtl/code_run_encoder.sv - run-length encoder of a 2-bit code stream into a FWFT record FIFO
// Optional macro RUN_FLUSH_EN adds a flush input that closes the open run on demand.
module code_run_encoder #(
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic [1:0]       code_in,
    input  logic             code_valid,
`ifdef RUN_FLUSH_EN
    input  logic             flush,
`endif
    output logic [1:0]       rec_code,
    output logic [LEN_W-1:0] rec_len,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             overflow
);

    localparam int               AW      = $clog2(FIFO_DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
    localparam logic             ST_IDLE = 1'b0;
    localparam logic             ST_RUN  = 1'b1;

    logic             state_q, state_d;
    logic [1:0]       cur_code_q, cur_code_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [LEN_W+1:0] mem_q [FIFO_DEPTH];

    logic             flush_w;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             wr_en;
    logic [LEN_W+1:0] head;

`ifdef RUN_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        cur_len_d  = cur_len_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (code_valid) begin
                    cur_code_d = code_in;
                    cur_len_d  = LEN_ONE;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                if (code_valid) begin
                    if (flush_w || code_in != cur_code_q || cur_len_q == MAX_LEN) begin
                        push       = 1'b1;
                        cur_code_d = code_in;
                        cur_len_d  = LEN_ONE;
                    end else begin
                        cur_len_d = cur_len_q + LEN_ONE;
                    end
                end else if (flush_w) begin
                    push      = 1'b1;
                    cur_len_d = '0;
                    state_d   = ST_IDLE;
                end
            end
        endcase
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && rec_ready;
    // Push into a full FIFO succeeds only when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d = overflow_q || (push && full && !pop);
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q    <= ST_IDLE;
            cur_code_q <= '0;
            cur_len_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_code_q <= cur_code_d;
            cur_len_q  <= cur_len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge _clock) begin
        if (!_reset && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cur_code_q, cur_len_q};
        end
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign rec_valid = !empty;
    assign rec_code  = empty ? 2'b00 : head[LEN_W+1:LEN_W];
    assign rec_len   = empty ? '0 : head[LEN_W-1:0];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_code_run_encoder.sv
// tb/tb_code_run_encoder.sv - table-driven bench for code_run_encoder (LEN_W=4, FIFO_DEPTH=4)
module tb_code_run_encoder;

    logic       clk;
    logic       rst;
    logic [1:0] code_in;
    logic       code_valid;
    logic       flush;
    logic [1:0] rec_code;
    logic [3:0] rec_len;
    logic       rec_valid;
    logic       rec_ready;
    logic       overflow;

    code_run_encoder #(.LEN_W(4), .FIFO_DEPTH(4)) dut (
        ._clock     (clk),
        ._reset     (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
`ifdef RUN_FLUSH_EN
        .flush      (flush),
`endif
        .rec_code   (rec_code),
        .rec_len    (rec_len),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       rst;
        logic       v;
        logic [1:0] c;
        logic       rdy;
        logic       fl;
        logic       ev;
        logic [1:0] ec;
        logic [3:0] el;
        logic       eo;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_fail;

    task automatic add(input string tag, input logic r, input logic v, input logic [1:0] c,
                       input logic rdy, input logic fl, input logic ev, input logic [1:0] ec,
                       input logic [3:0] el, input logic eo);
        vec_t x;
        x.tag = tag; x.rst = r; x.v = v; x.c = c; x.rdy = rdy; x.fl = fl;
        x.ev = ev; x.ec = ec; x.el = el; x.eo = eo;
        vecs.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within the wait limit");
        $finish;
    end

    initial begin
        rst = 1'b1; code_in = 2'd0; code_valid = 1'b0; flush = 1'b0; rec_ready = 1'b0;
        n_applied = 0; n_fail = 0;

        add("reset0", 1, 1, 2'd2, 1, 0, 0, 2'd0, 4'd0, 0);
        add("reset1", 1, 0, 2'd1, 1, 0, 0, 2'd0, 4'd0, 0);
        add("reset2", 1, 1, 2'd3, 0, 0, 0, 2'd0, 4'd0, 0);

        add("basic_a", 0, 1, 2'd2, 1, 0, 0, 2'd0, 4'd0, 0);
        add("basic_b", 0, 1, 2'd2, 1, 0, 0, 2'd0, 4'd0, 0);
        add("basic_c", 0, 1, 2'd2, 1, 0, 0, 2'd0, 4'd0, 0);
        add("basic_rec", 0, 1, 2'd1, 1, 0, 1, 2'd2, 4'd3, 0);
        add("basic_pop", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 0);
        add("basic_open", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 0);
        add("rst_b", 1, 0, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);

        for (int i = 0; i < 15; i++) add("sat_fill", 0, 1, 2'd3, 0, 0, 0, 2'd0, 4'd0, 0);
        add("sat_15", 0, 1, 2'd3, 0, 0, 1, 2'd3, 4'd15, 0);
        add("sat_16", 0, 1, 2'd3, 0, 0, 1, 2'd3, 4'd15, 0);
        add("sat_end", 0, 1, 2'd0, 0, 0, 1, 2'd3, 4'd15, 0);
        add("sat_pop1", 0, 0, 2'd0, 1, 0, 1, 2'd3, 4'd2, 0);
        add("sat_pop2", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 0);
        add("rst_s", 1, 0, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);

        add("gap_a", 0, 1, 2'd1, 1, 0, 0, 2'd0, 4'd0, 0);
        add("gap_b", 0, 0, 2'd2, 1, 0, 0, 2'd0, 4'd0, 0);
        add("gap_c", 0, 0, 2'd3, 1, 0, 0, 2'd0, 4'd0, 0);
        add("gap_d", 0, 1, 2'd1, 1, 0, 0, 2'd0, 4'd0, 0);
        add("gap_rec", 0, 1, 2'd2, 1, 0, 1, 2'd1, 4'd2, 0);
        add("gap_pop", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 0);
        add("gap_only", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 0);
        add("rst_g", 1, 0, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);

        add("full_1", 0, 1, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);
        add("full_2", 0, 1, 2'd1, 0, 0, 1, 2'd0, 4'd1, 0);
        add("full_3", 0, 1, 2'd0, 0, 0, 1, 2'd0, 4'd1, 0);
        add("full_4", 0, 1, 2'd1, 0, 0, 1, 2'd0, 4'd1, 0);
        add("full_5", 0, 1, 2'd0, 0, 0, 1, 2'd0, 4'd1, 0);
        add("full_drop", 0, 1, 2'd1, 0, 0, 1, 2'd0, 4'd1, 1);
        add("drain_1", 0, 0, 2'd0, 1, 0, 1, 2'd1, 4'd1, 1);
        add("drain_2", 0, 0, 2'd0, 1, 0, 1, 2'd0, 4'd1, 1);
        add("drain_3", 0, 0, 2'd0, 1, 0, 1, 2'd1, 4'd1, 1);
        add("drain_4", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 1);
        add("rdy_empty", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 1);
        add("rst_ovf", 1, 0, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);

        add("pp_1", 0, 1, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);
        add("pp_2", 0, 1, 2'd1, 0, 0, 1, 2'd0, 4'd1, 0);
        add("pp_3", 0, 1, 2'd0, 0, 0, 1, 2'd0, 4'd1, 0);
        add("pp_4", 0, 1, 2'd1, 0, 0, 1, 2'd0, 4'd1, 0);
        add("pp_5", 0, 1, 2'd0, 0, 0, 1, 2'd0, 4'd1, 0);
        add("pp_both", 0, 1, 2'd1, 1, 0, 1, 2'd1, 4'd1, 0);
        add("pp_d1", 0, 0, 2'd0, 1, 0, 1, 2'd0, 4'd1, 0);
        add("pp_d2", 0, 0, 2'd0, 1, 0, 1, 2'd1, 4'd1, 0);
        add("pp_d3", 0, 0, 2'd0, 1, 0, 1, 2'd0, 4'd1, 0);
        add("pp_d4", 0, 0, 2'd0, 1, 0, 0, 2'd0, 4'd0, 0);
        add("rst_pp", 1, 0, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);

`ifdef RUN_FLUSH_EN
        add("fl_a", 0, 1, 2'd2, 0, 0, 0, 2'd0, 4'd0, 0);
        add("fl_b", 0, 1, 2'd2, 0, 0, 0, 2'd0, 4'd0, 0);
        add("fl_rec", 0, 0, 2'd0, 0, 1, 1, 2'd2, 4'd2, 0);
        add("fl_hold", 0, 0, 2'd0, 0, 0, 1, 2'd2, 4'd2, 0);
        add("fl_idle", 0, 0, 2'd0, 0, 1, 1, 2'd2, 4'd2, 0);
        add("fl_new", 0, 1, 2'd2, 1, 0, 0, 2'd0, 4'd0, 0);
        add("fl_new_rec", 0, 1, 2'd3, 0, 0, 1, 2'd2, 4'd1, 0);
        add("fl_valid", 0, 1, 2'd3, 1, 1, 1, 2'd3, 4'd1, 0);
        add("rst_fl", 1, 0, 2'd0, 0, 0, 0, 2'd0, 4'd0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            code_valid = vecs[i].v;
            code_in    = vecs[i].c;
            rec_ready  = vecs[i].rdy;
            flush      = vecs[i].fl;
            @(posedge clk);
            #1;
            n_applied++;
            if (rec_valid !== vecs[i].ev || rec_code !== vecs[i].ec ||
                rec_len !== vecs[i].el || overflow !== vecs[i].eo) begin
                n_fail++;
                $display("FAIL %s (vec %0d): got valid=%0b code=%0d len=%0d ovf=%0b, want valid=%0b code=%0d len=%0d ovf=%0b",
                         vecs[i].tag, i, rec_valid, rec_code, rec_len, overflow,
                         vecs[i].ev, vecs[i].ec, vecs[i].el, vecs[i].eo);
            end
        end

        rst        = 1'b1;
        code_valid = 1'b1;
        code_in    = 2'd2;
        rec_ready  = 1'b0;
        flush      = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            code_valid = ~code_valid;
        end
        n_applied++;
        if (rec_valid !== 1'b0 || overflow !== 1'b0 || rec_code !== 2'd0 || rec_len !== 4'd0) begin
            n_fail++;
            $display("FAIL final_reset: got valid=%0b code=%0d len=%0d ovf=%0b, want all zero",
                     rec_valid, rec_code, rec_len, overflow);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
